// File: rtl/median_window_filter.sv
// Windowed median/min/max processor: a TAPS-entry tap window sorted by an odd-even transposition network.
// Define MEDIAN_STREAM_EN to add the stream_en input (shift-in taps with automatic sort start).
module median_window_filter #(
  parameter int WIDTH  = 8,
  parameter int TAPS   = 7,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic              wr_enable,
  input  logic              start,
  input  logic [1:0]        out_select,
`ifdef MEDIAN_STREAM_EN
  input  logic              stream_en,
`endif
  output logic [WIDTH-1:0]  data_out,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(TAPS);
  localparam logic [PW-1:0] LAST_PASS = PW'(TAPS - 1);
  localparam logic [ADDR_W:0] TAPS_L = (ADDR_W + 1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] taps   [TAPS];
  logic [WIDTH-1:0] s      [TAPS];
  logic [WIDTH-1:0] s_next [TAPS];
  logic [PW-1:0]    pass;
  logic [WIDTH-1:0] med_r, min_r, max_r;
  logic             addr_ok;
  logic             start_req;
  logic             shift_wr;

  assign addr_ok = ({1'b0, reg_addr} < TAPS_L);

`ifdef MEDIAN_STREAM_EN
  assign shift_wr = stream_en & wr_enable;
`else
  assign shift_wr = 1'b0;
`endif

  // A shift-in while idle doubles as a start request.
  assign start_req = start | shift_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (shift_wr) begin
      taps[0] <= data_in;
      for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
    end else if (wr_enable && addr_ok) begin
      taps[reg_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_n = S_LOAD;
      S_LOAD: begin
        busy    = 1'b1;
        state_n = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (pass == LAST_PASS) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pairs are disjoint within a pass, so every exchange reads the pre-pass array.
  always_comb begin
    s_next = s;
    for (int i = 0; i + 1 < TAPS; i++) begin
      if ((i[0] == pass[0]) && (s[i] > s[i+1])) begin
        s_next[i]   = s[i+1];
        s_next[i+1] = s[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) s[i] <= '0;
      pass  <= '0;
      med_r <= '0;
      min_r <= '0;
      max_r <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          s    <= taps;
          pass <= '0;
        end
        S_SORT: begin
          s    <= s_next;
          pass <= pass + PW'(1);
          if (pass == LAST_PASS) begin
            med_r <= s_next[TAPS/2];
            min_r <= s_next[0];
            max_r <= s_next[TAPS-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      case (out_select)
        2'b00:   data_out <= med_r;
        2'b01:   data_out <= min_r;
        2'b10:   data_out <= max_r;
        default: data_out <= addr_ok ? taps[reg_addr] : '0;
      endcase
    end
  end

endmodule
